// File: rtl/rom_arbiter.sv
// Arbitrates the single-port program ROM between instruction fetch (IF) and data read (DP).
// Optional macro BUS_ERR_EN adds the bus_err output for misaligned or out-of-range accesses.
module rom_arbiter #(
   parameter logic [15:0] BOUND_L     = 16'hC000,
   parameter logic [15:0] BOUND_U     = 16'hFFFF,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ack,
   output logic [15:0] if_data,
   input  logic        dp_req,
   input  logic [15:0] dp_addr,
   input  logic        dp_bw,
   output logic        dp_ack,
   output logic [15:0] dp_data,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_rdata,
   output logic        busy
`ifdef BUS_ERR_EN
   ,
   output logic        bus_err
`endif
);

   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] ACCESS    = 1'b1;
   localparam logic       OWN_IF    = 1'b0;
   localparam logic       OWN_DP    = 1'b1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   logic [0:0]  state;
   logic        owner;
   logic [3:0]  wait_cnt;
   logic        cur_byte;
   logic        cur_oor;
   logic        grant_valid;
   logic        grant_owner;
   logic [15:0] grant_addr;
   logic        grant_byte;
   logic        grant_oor;
   logic [15:0] read_data;

   // 17-bit compare so that BOUND_U - 1 never wraps around
   function automatic logic out_of_range(input logic [15:0] addr);
      logic [16:0] a;
      a = {1'b0, addr};
      return (a < {1'b0, BOUND_L}) || (a > ({1'b0, BOUND_U} - 17'd1));
   endfunction

   // In IDLE DP has priority; at completion only the non-owner may be granted
   always_comb begin
      grant_valid = 1'b0;
      grant_owner = OWN_IF;
      grant_addr  = {if_addr[15:1], 1'b0};
      grant_byte  = 1'b0;
      grant_oor   = out_of_range(if_addr);
      if ((state == IDLE || owner == OWN_IF) && dp_req) begin
         grant_valid = 1'b1;
         grant_owner = OWN_DP;
         grant_addr  = dp_bw ? dp_addr : {dp_addr[15:1], 1'b0};
         grant_byte  = dp_bw;
         grant_oor   = out_of_range(dp_addr);
      end else if ((state == IDLE || owner == OWN_DP) && if_req) begin
         grant_valid = 1'b1;
      end
   end

   always_comb begin
      read_data = mem_rdata;
      if (cur_oor)
         read_data = 16'h0000;
      else if (cur_byte)
         read_data = {8'h00, mem_rdata[7:0]};
   end

`ifdef BUS_ERR_EN
   logic grant_err;
   logic cur_err;

   assign grant_err = grant_oor | ((grant_owner == OWN_DP) & ~grant_byte & dp_addr[0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_err <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         if (state == IDLE || wait_cnt == 4'd0) begin
            if (state == ACCESS)
               bus_err <= cur_err;
            if (grant_valid)
               cur_err <= grant_err;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= OWN_IF;
         mem_addr <= 16'h0000;
         wait_cnt <= 4'd0;
         cur_byte <= 1'b0;
         cur_oor  <= 1'b0;
         if_ack   <= 1'b0;
         dp_ack   <= 1'b0;
         if_data  <= 16'h0000;
         dp_data  <= 16'h0000;
      end else begin
         if_ack <= 1'b0;
         dp_ack <= 1'b0;
         if (state == ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end else begin
            if (state == ACCESS) begin
               if (owner == OWN_DP) begin
                  dp_data <= read_data;
                  dp_ack  <= 1'b1;
               end else begin
                  if_data <= read_data;
                  if_ack  <= 1'b1;
               end
            end
            if (grant_valid) begin
               state    <= ACCESS;
               owner    <= grant_owner;
               mem_addr <= grant_addr;
               wait_cnt <= WAIT_INIT;
               cur_byte <= grant_byte;
               cur_oor  <= grant_oor;
            end else begin
               state <= IDLE;
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: one instance with no wait states, one with three.
// bus_err checks are compiled in only when BUS_ERR_EN is defined.
module tb_rom_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   int          vectors = 0;
   int          miscompares = 0;

   logic        if_req0, dp_req0, dp_bw0, if_ack0, dp_ack0, busy0;
   logic [15:0] if_addr0, dp_addr0, if_data0, dp_data0, mem_addr0, mem_rdata0;
   logic        if_req3, dp_req3, dp_bw3, if_ack3, dp_ack3, busy3;
   logic [15:0] if_addr3, dp_addr3, if_data3, dp_data3, mem_addr3, mem_rdata3;
`ifdef BUS_ERR_EN
   logic        bus_err0, bus_err3;
`endif

   always #5 clk = ~clk;

   rom_arbiter #(.WAIT_STATES(0)) u0 (
      .clk(clk), .rst(rst),
      .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0), .if_data(if_data0),
      .dp_req(dp_req0), .dp_addr(dp_addr0), .dp_bw(dp_bw0), .dp_ack(dp_ack0), .dp_data(dp_data0),
      .mem_addr(mem_addr0), .mem_rdata(mem_rdata0), .busy(busy0)
`ifdef BUS_ERR_EN
      , .bus_err(bus_err0)
`endif
   );

   rom_arbiter #(.WAIT_STATES(3)) u3 (
      .clk(clk), .rst(rst),
      .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_data(if_data3),
      .dp_req(dp_req3), .dp_addr(dp_addr3), .dp_bw(dp_bw3), .dp_ack(dp_ack3), .dp_data(dp_data3),
      .mem_addr(mem_addr3), .mem_rdata(mem_rdata3), .busy(busy3)
`ifdef BUS_ERR_EN
      , .bus_err(bus_err3)
`endif
   );

   // ROM contents: a few hand-placed bytes over a simple address pattern
   function automatic logic [7:0] rom_byte(input logic [15:0] a);
      case (a)
         16'hC000: return 8'h31;
         16'hC001: return 8'h40;
         16'hC003: return 8'hA5;
         16'hC004: return 8'h5A;
         16'hC010: return 8'h34;
         16'hC011: return 8'h12;
         default:  return a[7:0] ^ 8'h3C;
      endcase
   endfunction

   function automatic logic [15:0] rom_word(input logic [15:0] a);
      return {rom_byte(a + 16'd1), rom_byte(a)};
   endfunction

   always_comb mem_rdata0 = rom_word(mem_addr0);
   always_comb mem_rdata3 = rom_word(mem_addr3);

   task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1;
      if_req0 = 1'b1; dp_req0 = 1'b1; if_addr0 = 16'hC000; dp_addr0 = 16'hC000; dp_bw0 = 1'b0;
      if_req3 = 1'b0; dp_req3 = 1'b1; if_addr3 = 16'h0000; dp_addr3 = 16'hC010; dp_bw3 = 1'b0;

      // reset held two cycles with requests active
      @(negedge clk);
      @(negedge clk);
      check_output("rst_if_ack", {15'd0, if_ack0}, 16'h0);
      check_output("rst_dp_ack", {15'd0, dp_ack0}, 16'h0);
      check_output("rst_if_data", if_data0, 16'h0000);
      check_output("rst_dp_data", dp_data0, 16'h0000);
      check_output("rst_mem_addr", mem_addr0, 16'h0000);
      check_output("rst_busy", {15'd0, busy0}, 16'h0);
      check_output("rst_busy3", {15'd0, busy3}, 16'h0);
`ifdef BUS_ERR_EN
      check_output("rst_bus_err", {15'd0, bus_err0}, 16'h0);
`endif
      rst = 1'b0; if_req0 = 1'b0; dp_req0 = 1'b0; dp_req3 = 1'b0;
      @(negedge clk);

      // single fetch at an odd address
      if_addr0 = 16'hC001; if_req0 = 1'b1;
      @(negedge clk);
      check_output("f_mem_addr", mem_addr0, 16'hC000);
      check_output("f_busy", {15'd0, busy0}, 16'h1);
      check_output("f_ack_early", {15'd0, if_ack0}, 16'h0);
      @(negedge clk);
      check_output("f_ack", {15'd0, if_ack0}, 16'h1);
      check_output("f_data", if_data0, 16'h4031);
      check_output("f_no_regrant", {15'd0, busy0}, 16'h0);
`ifdef BUS_ERR_EN
      check_output("f_odd_no_err", {15'd0, bus_err0}, 16'h0);
`endif
      if_req0 = 1'b0;
      @(negedge clk);
      check_output("f_ack_pulse", {15'd0, if_ack0}, 16'h0);

      // simultaneous requests: DP first, IF immediately after
      if_addr0 = 16'hC002; dp_addr0 = 16'hC010; dp_bw0 = 1'b0;
      if_req0 = 1'b1; dp_req0 = 1'b1;
      @(negedge clk);
      check_output("s_mem_addr_dp", mem_addr0, 16'hC010);
      check_output("s_busy1", {15'd0, busy0}, 16'h1);
      check_output("s_no_ack", {15'd0, dp_ack0 | if_ack0}, 16'h0);
      @(negedge clk);
      check_output("s_dp_ack", {15'd0, dp_ack0}, 16'h1);
      check_output("s_if_ack_wait", {15'd0, if_ack0}, 16'h0);
      check_output("s_dp_data", dp_data0, 16'h1234);
      check_output("s_busy2", {15'd0, busy0}, 16'h1);
      check_output("s_mem_addr_if", mem_addr0, 16'hC002);
      dp_req0 = 1'b0;
      @(negedge clk);
      check_output("s_if_ack", {15'd0, if_ack0}, 16'h1);
      check_output("s_dp_ack_off", {15'd0, dp_ack0}, 16'h0);
      check_output("s_if_data", if_data0, 16'hA53E);
      check_output("s_dp_data_hold", dp_data0, 16'h1234);
      check_output("s_busy_end", {15'd0, busy0}, 16'h0);
      if_req0 = 1'b0;
      @(negedge clk);

      // byte read at an odd address
      dp_addr0 = 16'hC003; dp_bw0 = 1'b1; dp_req0 = 1'b1;
      @(negedge clk);
      check_output("b_mem_addr", mem_addr0, 16'hC003);
      @(negedge clk);
      check_output("b_ack", {15'd0, dp_ack0}, 16'h1);
      check_output("b_data", dp_data0, 16'h00A5);
`ifdef BUS_ERR_EN
      check_output("b_no_err", {15'd0, bus_err0}, 16'h0);
`endif
      dp_req0 = 1'b0;
      @(negedge clk);

      // misaligned word read
      dp_addr0 = 16'hC005; dp_bw0 = 1'b0; dp_req0 = 1'b1;
      @(negedge clk);
      check_output("m_mem_addr", mem_addr0, 16'hC004);
      @(negedge clk);
      check_output("m_ack", {15'd0, dp_ack0}, 16'h1);
      check_output("m_data", dp_data0, 16'h395A);
`ifdef BUS_ERR_EN
      check_output("m_bus_err", {15'd0, bus_err0}, 16'h1);
`endif
      dp_req0 = 1'b0;
      @(negedge clk);
`ifdef BUS_ERR_EN
      check_output("m_err_pulse", {15'd0, bus_err0}, 16'h0);
`endif

      // out-of-range word read below the ROM
      dp_addr0 = 16'h1000; dp_req0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_output("o_ack", {15'd0, dp_ack0}, 16'h1);
      check_output("o_data", dp_data0, 16'h0000);
`ifdef BUS_ERR_EN
      check_output("o_bus_err", {15'd0, bus_err0}, 16'h1);
`endif
      dp_req0 = 1'b0;
      @(negedge clk);

      // byte just below the lower bound
      dp_addr0 = 16'hBFFF; dp_bw0 = 1'b1; dp_req0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_output("lb_data", dp_data0, 16'h0000);
      dp_req0 = 1'b0; dp_bw0 = 1'b0;
      @(negedge clk);

      // highest in-range fetch, then the top address which is out of range
      if_addr0 = 16'hFFFE; if_req0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_output("ub_in_data", if_data0, 16'hC3C2);
      if_req0 = 1'b0;
      @(negedge clk);
      if_addr0 = 16'hFFFF; if_req0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_output("ub_out_ack", {15'd0, if_ack0}, 16'h1);
      check_output("ub_out_data", if_data0, 16'h0000);
`ifdef BUS_ERR_EN
      check_output("ub_out_err", {15'd0, bus_err0}, 16'h1);
`endif
      if_req0 = 1'b0;
      @(negedge clk);

      // three wait states
      dp_addr3 = 16'hC010; dp_req3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_output("w_no_ack", {15'd0, dp_ack3}, 16'h0);
         check_output("w_busy", {15'd0, busy3}, 16'h1);
      end
      @(negedge clk);
      check_output("w_ack", {15'd0, dp_ack3}, 16'h1);
      check_output("w_data", dp_data3, 16'h1234);
      dp_req3 = 1'b0;
      @(negedge clk);

      // reset in the middle of an access abandons it
      dp_addr3 = 16'hC000; dp_req3 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_output("r_busy", {15'd0, busy3}, 16'h0);
      check_output("r_ack", {15'd0, dp_ack3}, 16'h0);
      check_output("r_mem_addr", mem_addr3, 16'h0000);
      check_output("r_data", dp_data3, 16'h0000);
      rst = 1'b0; dp_req3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_output("r_ack_after", {15'd0, dp_ack3}, 16'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
